// File: rtl/pll_sup_pkg.sv
// rtl/pll_sup_pkg.sv - state encoding, default timing constants and counter sizing for the PLL lock supervisor
package pll_sup_pkg;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } pll_state_t;

  localparam int DEF_RST_PULSE     = 16;
  localparam int DEF_LOCK_TIMEOUT  = 50000;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_MAX_RETRY     = 3;

  // Counters only ever hold values up to n-1; keep at least one bit for tiny n.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous bit, reset value 0
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - sequences PLL reset, qualifies lock, retries on timeout and holds downstream logic in reset until lock is stable
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_PULSE     = DEF_RST_PULSE,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRY     = DEF_MAX_RETRY
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       locked_ok,
  output logic       fail,
  output logic [7:0] relock_cnt
);

  localparam int PW = cnt_w(RST_PULSE);
  localparam int TW = cnt_w(LOCK_TIMEOUT);
  localparam int SW = cnt_w(STABLE_CYCLES);
  localparam int RW = cnt_w(MAX_RETRY);

  pll_state_t    state, state_nxt;
  logic [PW-1:0] pulse_cnt, pulse_nxt;
  logic [TW-1:0] tmo_cnt, tmo_nxt;
  logic [SW-1:0] stab_cnt, stab_nxt;
  logic [RW-1:0] retry, retry_nxt;
  logic [7:0]    relock_nxt;
  logic          lock_s;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RESET_PLL;
      pulse_cnt  <= '0;
      tmo_cnt    <= '0;
      stab_cnt   <= '0;
      retry      <= '0;
      relock_cnt <= '0;
    end else begin
      state      <= state_nxt;
      pulse_cnt  <= pulse_nxt;
      tmo_cnt    <= tmo_nxt;
      stab_cnt   <= stab_nxt;
      retry      <= retry_nxt;
      relock_cnt <= relock_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pulse_nxt  = pulse_cnt;
    tmo_nxt    = tmo_cnt;
    stab_nxt   = stab_cnt;
    retry_nxt  = retry;
    relock_nxt = relock_cnt;
    case (state)
      RESET_PLL: begin
        if (pulse_cnt == PW'(RST_PULSE - 1)) begin
          state_nxt = WAIT_LOCK;
          pulse_nxt = '0;
          tmo_nxt   = '0;
        end else begin
          pulse_nxt = pulse_cnt + 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = STABLE;
          stab_nxt  = '0;
        end else if (tmo_cnt == TW'(LOCK_TIMEOUT - 1)) begin
          // The attempt that exhausts the retry budget parks in FAIL instead of pulsing again.
          if (retry == RW'(MAX_RETRY - 1)) begin
            state_nxt = FAIL;
          end else begin
            state_nxt = RESET_PLL;
            pulse_nxt = '0;
            retry_nxt = retry + 1'b1;
          end
        end else begin
          tmo_nxt = tmo_cnt + 1'b1;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          tmo_nxt   = '0;
        end else if (stab_cnt == SW'(STABLE_CYCLES - 1)) begin
          state_nxt = RUN;
          retry_nxt = '0;
        end else begin
          stab_nxt = stab_cnt + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt = RESET_PLL;
          pulse_nxt = '0;
          if (relock_cnt != 8'hFF) relock_nxt = relock_cnt + 8'd1;
        end
      end
      FAIL:    state_nxt = FAIL;
      default: state_nxt = RESET_PLL;
    endcase
  end

  assign pll_rst   = (state == RESET_PLL);
  assign sys_rst   = (state != RUN);
  assign locked_ok = (state == RUN);
  assign fail      = (state == FAIL);

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - directed self-checking bench for pll_lock_supervisor with scaled-down timing parameters
module tb_pll_lock_supervisor;

  localparam int P = 4;
  localparam int T = 20;
  localparam int S = 8;
  localparam int R = 3;
  localparam int N = P + T;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_lock;
  logic       pll_rst;
  logic       sys_rst;
  logic       locked_ok;
  logic       fail;
  logic [7:0] relock_cnt;

  int tests  = 0;
  int failed = 0;
  bit ok;

  pll_lock_supervisor #(
    .RST_PULSE     (P),
    .LOCK_TIMEOUT  (T),
    .STABLE_CYCLES (S),
    .MAX_RETRY     (R)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_lock   (pll_lock),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .locked_ok  (locked_ok),
    .fail       (fail),
    .relock_cnt (relock_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_run(output bit hit);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (locked_ok === 1'b1) hit = 1'b1;
      else step(1);
    end
  endtask

  task automatic wait_fail(output bit hit);
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      if (fail === 1'b1) hit = 1'b1;
      else step(1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    pll_lock = 1'b1;
    step(2);
    check("rst_pll_rst",   pll_rst,    1);
    check("rst_sys_rst",   sys_rst,    1);
    check("rst_locked_ok", locked_ok,  0);
    check("rst_fail",      fail,       0);
    check("rst_relock",    relock_cnt, 0);

    // Lock high from the start: pulse of P cycles, one WAIT_LOCK cycle, S STABLE cycles, then RUN.
    rst = 1'b0;
    for (int k = 0; k <= P + S + 1; k++) begin
      if (k > 0) step(1);
      check($sformatf("up_pll_rst_c%0d", k), pll_rst, (k < P));
      check($sformatf("up_sys_rst_c%0d", k), sys_rst, (k <= P + S));
    end
    check("up_locked_ok", locked_ok, 1);

    // Two-cycle lock loss in RUN: sys_rst on the third edge, new pulse, relock count 1.
    pll_lock = 1'b0;
    step(1);
    check("drop_e1_sys_rst", sys_rst, 0);
    step(1);
    pll_lock = 1'b1;
    check("drop_e2_sys_rst", sys_rst, 0);
    step(1);
    check("drop_e3_sys_rst", sys_rst,    1);
    check("drop_e3_pll_rst", pll_rst,    1);
    check("drop_relock",     relock_cnt, 1);
    check("drop_locked_ok",  locked_ok,  0);
    for (int i = 1; i < P; i++) begin
      step(1);
      check($sformatf("relock_pulse_%0d", i), pll_rst, 1);
    end
    step(1);
    check("relock_pulse_end", pll_rst, 0);

    // One-cycle glitch while STABLE count is S-3 restarts qualification.
    step(4);
    pll_lock = 1'b0;
    step(1);
    pll_lock = 1'b1;
    step(4);
    check("glitch_no_early_run", sys_rst, 1);
    step(6);
    check("glitch_still_rst", sys_rst, 1);
    step(1);
    check("glitch_run_sys_rst", sys_rst,    0);
    check("glitch_run_locked",  locked_ok,  1);
    check("glitch_relock",      relock_cnt, 1);

    // Reset in RUN with lock tied low: three pulses N apart, then FAIL.
    pll_lock = 1'b0;
    rst      = 1'b1;
    step(1);
    check("rst_in_run_pll_rst", pll_rst,    1);
    check("rst_in_run_relock",  relock_cnt, 0);
    rst = 1'b0;
    for (int k = 0; k <= 3 * N + 30; k++) begin
      if (k > 0) step(1);
      check($sformatf("low_pll_rst_c%0d", k), pll_rst, (k < 3 * N) && ((k % N) < P));
      check($sformatf("low_fail_c%0d", k),    fail,    (k >= 3 * N));
      check($sformatf("low_sys_rst_c%0d", k), sys_rst, 1);
    end
    pll_lock = 1'b1;
    step(20);
    check("fail_terminal",        fail,      1);
    check("fail_terminal_locked", locked_ok, 0);
    check("fail_terminal_pllrst", pll_rst,   0);

    // Reset from FAIL, then 300 forced lock losses in RUN saturate relock_cnt.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    wait_run(ok);
    check("sat_first_run", ok, 1);
    for (int i = 1; i <= 300; i++) begin
      pll_lock = 1'b0;
      step(2);
      pll_lock = 1'b1;
      step(1);
      if (i == 1)   check("sat_relock_1",   relock_cnt, 1);
      if (i == 255) check("sat_relock_255", relock_cnt, 255);
      wait_run(ok);
      if (!ok) check($sformatf("sat_run_%0d", i), ok, 1);
    end
    check("sat_relock_final", relock_cnt, 255);

    pll_lock = 1'b0;
    wait_fail(ok);
    check("sat_reach_fail",  ok,         1);
    check("sat_fail_relock", relock_cnt, 255);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("fail_rst_fail",    fail,       0);
    check("fail_rst_relock",  relock_cnt, 0);
    check("fail_rst_pll_rst", pll_rst,    1);
    for (int i = 1; i < P; i++) begin
      step(1);
      check($sformatf("fail_rst_pulse_%0d", i), pll_rst, 1);
    end
    step(1);
    check("fail_rst_pulse_end", pll_rst, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
